// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation or vectoring mode,
// quadrant-folded to cover +/-pi, gain-compensated outputs with saturation.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// PRE   | quadrant fold so the remaining angle lies within CORDIC convergence
// ITER  | ITERATIONS micro-rotations, one per cycle
// SCALE | multiply x and y by the CORDIC gain compensation K
// DONE  | round/saturate into the output registers; done pulses next cycle
module cordic_iter #(
  parameter int WIDTH      = 16,
  parameter int ITERATIONS = 14,
  parameter int GUARD      = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic signed [WIDTH-1:0] xin,
  input  logic signed [WIDTH-1:0] yin,
  input  logic signed [WIDTH-1:0] zin,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] xout,
  output logic signed [WIDTH-1:0] yout,
  output logic signed [WIDTH-1:0] zout
);

  localparam int IW  = WIDTH + GUARD + 2;
  localparam int ZW  = WIDTH + GUARD;
  localparam int CW  = $clog2(ITERATIONS);
  localparam int TN  = 2 ** CW;
  localparam int PW  = IW + 16;
  localparam int PSH = 15 + GUARD;
  localparam logic signed [PW-1:0] KS    = PW'(19898);
  localparam logic signed [PW-1:0] PHALF = PW'(1) <<< (PSH - 1);
  localparam logic signed [PW-1:0] SMAX  = (PW'(1) <<< (WIDTH - 1)) - PW'(1);
  localparam logic signed [PW-1:0] SMIN  = -SMAX - PW'(1);
  localparam logic [ZW-1:0]        ZHALF = ZW'((2 ** GUARD) / 2);
  localparam logic [127:0]         PI_Q60 = 128'h3243F6A8885A308D;

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_ITER, S_SCALE, S_DONE} state_t;

  // atan(2^-i)/pi scaled to the internal angle width, via the arctan series in Q60
  function automatic logic [ZW-1:0] atan_val(input int i);
    logic [127:0] acc;
    logic [127:0] term;
    int sh;
    acc = '0;
    for (int k = 0; k < 32; k++) begin
      sh = i * (2 * k + 1);
      if (i > 0 && sh <= 60) begin
        term = (128'(1) << 60) >> sh;
        term = term / 128'(2 * k + 1);
        if (k % 2 == 0) acc = acc + term;
        else            acc = acc - term;
      end
    end
    if (i == 0) atan_val = ZW'(1) << (ZW - 3);
    else        atan_val = ZW'(((acc << (ZW - 1)) + (PI_Q60 >> 1)) / PI_Q60);
  endfunction

  function automatic logic signed [WIDTH-1:0] sat_round(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] r;
    r = (p + PHALF) >>> PSH;
    if (r > SMAX)      r = SMAX;
    else if (r < SMIN) r = SMIN;
    return WIDTH'(r);
  endfunction

  logic [ZW-1:0] atan_tab [TN];
  for (genvar g = 0; g < TN; g++) begin : g_atan
    localparam logic [ZW-1:0] A = (g < ITERATIONS) ? atan_val(g) : '0;
    assign atan_tab[g] = A;
  end

  state_t               state, state_nxt;
  logic [CW-1:0]        iter;
  logic signed [IW-1:0] x_r, y_r, x_sh, y_sh;
  logic signed [ZW-1:0] z_r;
  logic signed [PW-1:0] px_r, py_r;
  logic                 mode_r, zero_r, d_pos, fold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_PRE;
      S_PRE:   state_nxt = S_ITER;
      S_ITER:  if (iter == CW'(ITERATIONS - 1)) state_nxt = S_SCALE;
      S_SCALE: state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_comb begin
    x_sh  = x_r >>> iter;
    y_sh  = y_r >>> iter;
    d_pos = mode_r ? y_r[IW-1] : ~z_r[ZW-1];
    fold  = mode_r ? x_r[IW-1] : (z_r[ZW-1] != z_r[ZW-2]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iter   <= '0;
      x_r    <= '0;
      y_r    <= '0;
      z_r    <= '0;
      px_r   <= '0;
      py_r   <= '0;
      mode_r <= 1'b0;
      zero_r <= 1'b0;
      done   <= 1'b0;
      xout   <= '0;
      yout   <= '0;
      zout   <= '0;
    end else begin
      done <= (state == S_DONE);
      case (state)
        S_IDLE: if (start) begin
          iter   <= '0;
          x_r    <= IW'(xin) <<< GUARD;
          y_r    <= IW'(yin) <<< GUARD;
          z_r    <= ZW'(zin) <<< GUARD;
          mode_r <= mode;
          zero_r <= (xin == '0) && (yin == '0);
        end
        S_PRE: if (fold) begin
          x_r <= -x_r;
          y_r <= -y_r;
          z_r <= {~z_r[ZW-1], z_r[ZW-2:0]};
        end
        S_ITER: begin
          iter <= iter + CW'(1);
          // A zero vector has no angle; keep z so the result is just zin.
          if (d_pos) begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            if (!(mode_r && zero_r)) z_r <= z_r - atan_tab[iter];
          end else begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            if (!(mode_r && zero_r)) z_r <= z_r + atan_tab[iter];
          end
        end
        S_SCALE: begin
          iter <= '0;
          px_r <= PW'(x_r) * KS;
          py_r <= PW'(y_r) * KS;
        end
        S_DONE: begin
          xout <= sat_round(px_r);
          yout <= sat_round(py_r);
          zout <= WIDTH'((z_r + ZHALF) >> GUARD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Self-checking bench for cordic_iter: directed corner cases plus random operands
// compared against a real-arithmetic model of rotation and vectoring.
module tb_cordic_iter;
  localparam real PI = 3.14159265358979323846;

  logic               clk, reset, start, mode;
  logic signed [15:0] xin, yin, zin;
  logic               busy, done;
  logic signed [15:0] xout, yout, zout;

  int checks = 0;
  int errors = 0;

  cordic_iter #(.WIDTH(16), .ITERATIONS(14), .GUARD(2)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .xin(xin), .yin(yin), .zin(zin),
    .busy(busy), .done(done), .xout(xout), .yout(yout), .zout(zout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real clampr(input real v);
    if (v > 32767.0)  return 32767.0;
    if (v < -32768.0) return -32768.0;
    return v;
  endfunction

  function automatic real wrapd(input real d);
    real r;
    r = d;
    while (r > 32768.0)  r = r - 65536.0;
    while (r < -32768.0) r = r + 65536.0;
    return r;
  endfunction

  task automatic chk_eq(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input real expv, input bit wrap);
    real d;
    d = real'(obs) - expv;
    if (wrap) d = wrapd(d);
    checks++;
    assert (d <= 4.0 && d >= -4.0) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0.2f", tag, obs, expv);
    end
  endtask

  // Mathematical result of one operation, independent of how the engine iterates.
  task automatic model(input logic m, input int x, input int y, input int z,
                       output real ex, output real ey, output real ez);
    real th;
    if (!m) begin
      th = real'(z) * PI / 32768.0;
      ex = real'(x) * $cos(th) - real'(y) * $sin(th);
      ey = real'(x) * $sin(th) + real'(y) * $cos(th);
      ez = 0.0;
    end else begin
      ex = $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
      ey = 0.0;
      ez = real'(z) + $atan2(real'(y), real'(x)) * 32768.0 / PI;
    end
    ex = clampr(ex);
    ey = clampr(ey);
  endtask

  // lat counts rising edges after the accepting edge until done is seen.
  task automatic run_op(input logic m, input int x, input int y, input int z,
                        output int lat, output logic busy0);
    @(negedge clk);
    mode = m; xin = 16'(x); yin = 16'(y); zin = 16'(z); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy0 = busy;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_op(input string tag, input logic m, input int x, input int y, input int z);
    int lat;
    logic b0;
    real ex, ey, ez;
    run_op(m, x, y, z, lat, b0);
    model(m, x, y, z, ex, ey, ez);
    chk_eq({tag, "_lat"}, lat, 17);
    chk_eq({tag, "_busy"}, int'(b0), 1);
    chk_tol({tag, "_x"}, int'(xout), ex, 1'b0);
    chk_tol({tag, "_y"}, int'(yout), ey, 1'b0);
    chk_tol({tag, "_z"}, int'(zout), ez, 1'b1);
  endtask

  initial begin
    int lat, nd, first, second, got, x, y, z;
    logic b0, m;

    reset = 1'b0; start = 1'b0; mode = 1'b0; xin = '0; yin = '0; zin = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("rst_busy", int'(busy), 0);
    chk_eq("rst_done", int'(done), 0);
    chk_eq("rst_xout", int'(xout), 0);
    chk_eq("rst_yout", int'(yout), 0);
    chk_eq("rst_zout", int'(zout), 0);
    @(negedge clk); reset = 1'b1;

    check_op("rot_pi2", 1'b0, 16384, 0, 16384);
    check_op("rot_fold", 1'b0, 10000, 0, -32768);
    check_op("vec_345", 1'b1, 3000, 4000, 0);
    check_op("vec_neg", 1'b1, -3000, -4000, 0);
    check_op("rot_minx", 1'b0, -32768, 0, 0);
    check_op("vec_minx", 1'b1, -32768, 0, 0);

    run_op(1'b0, 32767, 32767, 8192, lat, b0);
    chk_eq("sat_lat", lat, 17);
    chk_eq("sat_yout", int'(yout), 32767);
    chk_tol("sat_xout", int'(xout), 0.0, 1'b0);

    run_op(1'b1, 0, 0, 1234, lat, b0);
    chk_eq("zero_xout", int'(xout), 0);
    chk_eq("zero_yout", int'(yout), 0);
    chk_eq("zero_zout", int'(zout), 1234);
    @(negedge clk); mode = 1'b0; xin = 16'sd777; yin = -16'sd555; zin = 16'sd999;
    repeat (5) @(posedge clk);
    #1;
    chk_eq("hold_xout", int'(xout), 0);
    chk_eq("hold_yout", int'(yout), 0);
    chk_eq("hold_zout", int'(zout), 1234);

    // start held high for 40 cycles
    @(negedge clk);
    mode = 1'b0; xin = 16'sd1000; yin = '0; zin = '0; start = 1'b1;
    nd = 0; first = -1; second = -1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) begin
        nd++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    start = 1'b0;
    chk_eq("hs_count", nd, 2);
    chk_eq("hs_first", first, 17);
    chk_eq("hs_spacing", second - first, 18);
    got = 0;
    for (int c = 0; c < 30 && got == 0; c++) begin
      @(posedge clk); #1;
      if (done) got = 1;
    end
    chk_eq("hs_drain", got, 1);
    chk_tol("hs_xout", int'(xout), 1000.0, 1'b0);

    // reset during iteration 5
    @(negedge clk);
    mode = 1'b0; xin = 16'sd5000; yin = 16'sd2000; zin = 16'sd3000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1; reset = 1'b0; #1;
    chk_eq("mid_busy", int'(busy), 0);
    chk_eq("mid_done", int'(done), 0);
    chk_eq("mid_xout", int'(xout), 0);
    chk_eq("mid_yout", int'(yout), 0);
    chk_eq("mid_zout", int'(zout), 0);
    @(negedge clk); reset = 1'b1;
    nd = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (done) nd++;
    end
    chk_eq("mid_nodone", nd, 0);
    check_op("post_rst", 1'b0, 5000, 2000, 3000);

    for (int n = 0; n < 12; n++) begin
      m = 1'($urandom_range(1));
      x = int'($urandom_range(24000)) - 12000;
      y = int'($urandom_range(24000)) - 12000;
      z = int'($urandom_range(65535)) - 32768;
      if (m && (x < 3000 && x > -3000) && (y < 3000 && y > -3000)) x = 5000;
      check_op($sformatf("rnd%0d", n), m, x, y, z);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
